// File: rtl/traffic_light_ctrl_n.sv
// N-way traffic light sequencer with per-direction skip and flashing mode.
// Define TL_ALLRED_EN to insert an all-red clearance phase between yellow and green.
module traffic_light_ctrl_n #(
  parameter int NUM_DIR    = 4,
  parameter int CLK_FREQ   = 100000,
  parameter int GREEN_SEC  = 5,
  parameter int YELLOW_SEC = 1,
  parameter int ALLRED_SEC = 1,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_DIR-1:0]         skip_mask,
  output logic [2*NUM_DIR-1:0]       signal,
  output logic [$clog2(NUM_DIR)-1:0] cur_dir,
  output logic                       flash
);

  localparam int DIR_W = $clog2(NUM_DIR);
  localparam int SIG_W = 2 * NUM_DIR;
  localparam logic [1:0] LAMP_Y = 2'b01;
  localparam logic [1:0] LAMP_G = 2'b10;
  localparam logic [SIG_W-1:0] ALL_Y = {NUM_DIR{LAMP_Y}};

`ifdef TL_ALLRED_EN
  typedef enum logic [2:0] {S_INIT, S_GREEN, S_YELLOW, S_FLASH, S_ALLRED} state_t;
`else
  typedef enum logic [1:0] {S_INIT, S_GREEN, S_YELLOW, S_FLASH} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pre_q, pre_d;
  logic [31:0]        sec_q, sec_d;
  logic [DIR_W-1:0]   cur_q, cur_d, nxt_q, nxt_d;
  logic               fy_q, fy_d;
  logic [SIG_W-1:0]   signal_q, signal_d;
  logic               flash_q, flash_d;
  logic               sec_tick, phase_done, entry;

  function automatic int dur_sec(state_t st);
    case (st)
      S_GREEN:  return GREEN_SEC;
      S_YELLOW: return YELLOW_SEC;
`ifdef TL_ALLRED_EN
      S_ALLRED: return ALLRED_SEC;
`endif
      default:  return 1;
    endcase
  endfunction

  // First non-skipped direction after cd, wrapping; cd itself is reached last.
  function automatic logic [DIR_W-1:0] pick_next(logic [DIR_W-1:0] cd,
                                                 logic [NUM_DIR-1:0] m);
    logic [DIR_W-1:0] r;
    logic [31:0]      c;
    r = DIR_W'((int'(cd) + 1) % NUM_DIR);
    for (int k = NUM_DIR; k >= 1; k--) begin
      c = 32'((int'(cd) + k) % NUM_DIR);
      if (!m[c[DIR_W-1:0]]) r = c[DIR_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [SIG_W-1:0] lamps(state_t st, logic [DIR_W-1:0] cd,
                                             logic [DIR_W-1:0] nd, logic fy);
    logic [SIG_W-1:0] s;
    s = '0;
    case (st)
      S_INIT:  s = ALL_Y;
      S_FLASH: s = fy ? ALL_Y : '0;
      S_GREEN: begin
        for (int i = 0; i < NUM_DIR; i++)
          if (int'(cd) == i) s[SIG_W-1-2*i -: 2] = LAMP_G;
      end
      S_YELLOW: begin
        for (int i = 0; i < NUM_DIR; i++)
          if (int'(cd) == i || int'(nd) == i) s[SIG_W-1-2*i -: 2] = LAMP_Y;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  assign sec_tick   = (pre_q == CNT_W'(CLK_FREQ - 1));
  assign phase_done = sec_tick && (sec_q == 32'(dur_sec(state_q) - 1));

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    fy_d    = fy_q;
    entry   = 1'b0;
    if (state_q != S_FLASH && !enable) begin
      state_d = S_FLASH;
      fy_d    = 1'b1;
      entry   = 1'b1;
    end else if (state_q == S_FLASH && enable) begin
      state_d = S_INIT;
      cur_d   = '0;
      entry   = 1'b1;
    end else if (phase_done) begin
      entry = 1'b1;
      case (state_q)
        S_INIT: begin
          state_d = S_GREEN;
          cur_d   = '0;
        end
        S_GREEN: begin
          state_d = S_YELLOW;
          nxt_d   = pick_next(cur_q, skip_mask);
        end
`ifdef TL_ALLRED_EN
        S_YELLOW: state_d = S_ALLRED;
        S_ALLRED: begin
          state_d = S_GREEN;
          cur_d   = nxt_q;
        end
`else
        S_YELLOW: begin
          state_d = S_GREEN;
          cur_d   = nxt_q;
        end
`endif
        // Flash phases are re-entered every second with the lamp phase flipped.
        S_FLASH: fy_d = !fy_q;
        default: state_d = S_INIT;
      endcase
    end
    pre_d    = (entry || sec_tick) ? '0 : pre_q + CNT_W'(1);
    sec_d    = entry ? '0 : (sec_tick ? sec_q + 32'd1 : sec_q);
    signal_d = lamps(state_d, cur_d, nxt_d, fy_d);
    flash_d  = (state_d == S_FLASH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      pre_q    <= '0;
      sec_q    <= '0;
      cur_q    <= '0;
      nxt_q    <= '0;
      fy_q     <= 1'b0;
      signal_q <= ALL_Y;
      flash_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      sec_q    <= sec_d;
      cur_q    <= cur_d;
      nxt_q    <= nxt_d;
      fy_q     <= fy_d;
      signal_q <= signal_d;
      flash_q  <= flash_d;
    end
  end

  assign signal  = signal_q;
  assign cur_dir = cur_q;
  assign flash   = flash_q;

endmodule
